// File: rtl/mult_div_unit.sv
// Multi-cycle integer multiply/divide unit holding the HI/LO registers.
// Optional MD_FAST_MULT_EN: single-cycle combinational MULT/MULTU.
module mult_div_unit #(
  parameter int N_BITS = 32,
  parameter int N_OP   = 3,
  parameter int N_CNT  = 6
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [N_OP-1:0]   md_op_i,
  input  logic [N_BITS-1:0] A,
  input  logic [N_BITS-1:0] B,
  input  logic              flush_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [N_BITS-1:0] hi_o,
  output logic [N_BITS-1:0] lo_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  typedef enum logic [N_OP-1:0] {
    OP_NOP   = N_OP'(0),
    OP_MULT  = N_OP'(1),
    OP_MULTU = N_OP'(2),
    OP_DIV   = N_OP'(3),
    OP_DIVU  = N_OP'(4),
    OP_MTHI  = N_OP'(5),
    OP_MTLO  = N_OP'(6),
    OP_RSVD  = N_OP'(7)
  } op_t;

  state_t                state;
  logic [N_CNT-1:0]      cnt;
  logic [2*N_BITS-1:0]   acc;
  logic [N_BITS-1:0]     opnd;
  logic                  is_div;
  logic                  neg_q;
  logic                  neg_r;
  logic                  b_zero;

  op_t                   op;
  logic                  op_mult, op_div, op_signed, a_neg, b_neg;
  logic [N_BITS-1:0]     a_mag, b_mag;

  logic [N_BITS-1:0]     addend;
  logic [N_BITS:0]       add_sum;
  logic [N_BITS:0]       rem_sh;
  logic [N_BITS-1:0]     rem_diff;
  logic [2*N_BITS-1:0]   mul_next, div_next, prod_fix;
  logic [N_BITS-1:0]     quot_fix, rem_fix;

  assign op = op_t'(md_op_i);

  always_comb begin
    op_mult   = (op == OP_MULT) || (op == OP_MULTU);
    op_div    = (op == OP_DIV)  || (op == OP_DIVU);
    op_signed = (op == OP_MULT) || (op == OP_DIV);
    a_neg     = op_signed && A[N_BITS-1];
    b_neg     = op_signed && B[N_BITS-1];
    a_mag     = a_neg ? -A : A;
    b_mag     = b_neg ? -B : B;
  end

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient};
  // opnd holds the multiplicand or divisor magnitude.
  always_comb begin
    addend   = acc[0] ? opnd : '0;
    add_sum  = {1'b0, acc[2*N_BITS-1:N_BITS]} + {1'b0, addend};
    mul_next = {add_sum, acc[N_BITS-1:1]};

    rem_sh   = {acc[2*N_BITS-1:N_BITS], acc[N_BITS-1]};
    rem_diff = rem_sh[N_BITS-1:0] - opnd;
    if (rem_sh >= {1'b0, opnd})
      div_next = {rem_diff, acc[N_BITS-2:0], 1'b1};
    else
      div_next = {rem_sh[N_BITS-1:0], acc[N_BITS-2:0], 1'b0};
  end

  // With a zero divisor every trial subtract succeeds, so the remainder ends
  // as |A|; re-applying A's sign restores the raw dividend for HI.
  always_comb begin
    prod_fix = neg_q ? -acc : acc;
    rem_fix  = neg_r ? -acc[2*N_BITS-1:N_BITS] : acc[2*N_BITS-1:N_BITS];
    if (b_zero)
      quot_fix = '1;
    else
      quot_fix = neg_q ? -acc[N_BITS-1:0] : acc[N_BITS-1:0];
  end

`ifdef MD_FAST_MULT_EN
  logic [2*N_BITS-1:0] a_ext, b_ext, fast_prod;
  always_comb begin
    a_ext     = {{N_BITS{a_neg}}, A};
    b_ext     = {{N_BITS{b_neg}}, B};
    fast_prod = a_ext * b_ext;
  end
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state  <= S_IDLE;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      hi_o   <= '0;
      lo_o   <= '0;
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      b_zero <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_i && !flush_i) begin
`ifdef MD_FAST_MULT_EN
            if (op_mult) begin
              hi_o   <= fast_prod[2*N_BITS-1:N_BITS];
              lo_o   <= fast_prod[N_BITS-1:0];
              done_o <= 1'b1;
            end else
`endif
            if (op_mult || op_div) begin
              acc    <= {{N_BITS{1'b0}}, op_div ? a_mag : b_mag};
              opnd   <= op_div ? b_mag : a_mag;
              is_div <= op_div;
              neg_q  <= a_neg ^ b_neg;
              neg_r  <= a_neg;
              b_zero <= (B == '0);
              cnt    <= '0;
              busy_o <= 1'b1;
              state  <= S_RUN;
            end else if (op == OP_MTHI) begin
              hi_o <= A;
            end else if (op == OP_MTLO) begin
              lo_o <= A;
            end
          end
        end
        S_RUN: begin
          if (flush_i) begin
            busy_o <= 1'b0;
            state  <= S_IDLE;
          end else begin
            acc <= is_div ? div_next : mul_next;
            cnt <= cnt + 1'b1;
            if (cnt == N_CNT'(N_BITS - 1))
              state <= S_FIX;
          end
        end
        S_FIX: begin
          busy_o <= 1'b0;
          state  <= S_IDLE;
          if (!flush_i) begin
            if (is_div) begin
              hi_o <= rem_fix;
              lo_o <= quot_fix;
            end else begin
              hi_o <= prod_fix[2*N_BITS-1:N_BITS];
              lo_o <= prod_fix[N_BITS-1:0];
            end
            done_o <= 1'b1;
          end
        end
        default: begin
          busy_o <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit with a transaction-level
// HI/LO model; honours MD_FAST_MULT_EN when defined.
module tb_mult_div_unit;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
  localparam int DIV_BUSY = 33;
`ifdef MD_FAST_MULT_EN
  localparam int MUL_BUSY = 0;
`else
  localparam int MUL_BUSY = 33;
`endif

  logic        clk = 1'b0;
  logic        reset, start, flush;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy_o, done_o;
  logic [31:0] hi_o, lo_o;

  always #5 clk = ~clk;

  mult_div_unit #(.N_BITS(32), .N_OP(3), .N_CNT(6)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .md_op_i(op),
    .A(a), .B(b), .flush_i(flush),
    .busy_o(busy_o), .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  int checks = 0;
  int passes = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Architectural result {HI, LO} straight from the arithmetic definition.
  function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      OP_MULT:  return sx * sy;
      OP_MULTU: return {32'b0, x} * {32'b0, y};
      OP_DIV: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
      OP_DIVU: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
      default: return 64'd0;
    endcase
  endfunction

  logic        m_busy, m_done;
  logic [31:0] m_hi, m_lo;
  logic [63:0] m_pend;
  int          m_left = 0;

  // Model: an accepted op commits its result 33 edges later unless squashed.
  always @(posedge clk) begin
    if (reset) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_hi <= '0; m_lo <= '0; m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_left > 0) begin
        if (flush) begin
          m_left <= 0; m_busy <= 1'b0;
        end else begin
          m_left <= m_left - 1;
          if (m_left == 1) begin
            m_hi <= m_pend[63:32]; m_lo <= m_pend[31:0];
            m_done <= 1'b1; m_busy <= 1'b0;
          end
        end
      end else if (start && !flush) begin
        if (op == OP_MTHI) m_hi <= a;
        else if (op == OP_MTLO) m_lo <= a;
        else if (op >= OP_MULT && op <= OP_DIVU) begin
`ifdef MD_FAST_MULT_EN
          if (op <= OP_MULTU) begin
            m_hi <= ref_result(op, a, b) >> 32;
            m_lo <= ref_result(op, a, b) & 64'hFFFF_FFFF;
            m_done <= 1'b1;
          end else
`endif
          begin
            m_pend <= ref_result(op, a, b);
            m_left <= 33;
            m_busy <= 1'b1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc busy", busy_o, m_busy);
      chk("cyc done", done_o, m_done);
      chk("cyc hi", hi_o, m_hi);
      chk("cyc lo", lo_o, m_lo);
    end
  end

  task automatic drive(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = OP_NOP; a = $urandom; b = $urandom;
  endtask

  task automatic mt(input logic [2:0] o, input logic [31:0] x);
    drive(o, x, 32'h0);
    chk("mt busy", busy_o, 1'b0);
    chk("mt done", done_o, 1'b0);
  endtask

  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el,
                        input int eb, input int inj_at, input logic [2:0] inj_op);
    int nb;
    bit seen;
    nb = 0;
    seen = 1'b0;
    drive(o, x, y);
    for (int i = 0; i < 60; i++) begin
      if (done_o) begin seen = 1'b1; break; end
      if (busy_o) nb++;
      if (i == inj_at) begin
        start = 1'b1; op = inj_op; a = 32'h0BAD_0BAD; b = 32'h3;
      end else begin
        start = 1'b0; op = OP_NOP;
      end
      @(negedge clk);
    end
    start = 1'b0; op = OP_NOP;
    chk({name, " done seen"}, seen, 1'b1);
    chk({name, " hi"}, hi_o, eh);
    chk({name, " lo"}, lo_o, el);
    chk({name, " model hi"}, m_hi, eh);
    chk({name, " model lo"}, m_lo, el);
    chk({name, " busy cycles"}, nb, eb);
  endtask

  task automatic watch_no_done(input string name, input int n);
    int nd;
    nd = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done_o || busy_o) nd++;
    end
    chk({name, " quiet"}, nd, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; flush = 1'b0; op = OP_NOP; a = '0; b = '0;
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    chk("reset hi", hi_o, 32'h0);
    chk("reset lo", lo_o, 32'h0);
    chk("reset busy", busy_o, 1'b0);
    chk("reset done", done_o, 1'b0);
    reset = 1'b0;

    mt(OP_MTHI, 32'h1234_5678);
    mt(OP_MTLO, 32'h9ABC_DEF0);
    @(negedge clk);
    chk("mthi", hi_o, 32'h1234_5678);
    chk("mtlo", lo_o, 32'h9ABC_DEF0);

    run_op("mult -3*5", OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, MUL_BUSY, -1, OP_NOP);
    run_op("multu max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MUL_BUSY, -1, OP_NOP);
    run_op("mult min*min", OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, MUL_BUSY, -1, OP_NOP);
    run_op("mult -1*-1", OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, MUL_BUSY, -1, OP_NOP);
    run_op("divu 100/7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, DIV_BUSY, -1, OP_NOP);
    run_op("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_BUSY, -1, OP_NOP);
    run_op("div 7/-2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, DIV_BUSY, -1, OP_NOP);
    run_op("div ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, DIV_BUSY, -1, OP_NOP);
    run_op("div 55/0", OP_DIV, 32'd55, 32'd0, 32'd55, 32'hFFFF_FFFF, DIV_BUSY, 5, OP_MULTU);
    run_op("div -9/0", OP_DIV, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFF7, 32'hFFFF_FFFF, DIV_BUSY, 12, OP_MTHI);
    run_op("divu big/0", OP_DIVU, 32'hF000_0001, 32'd0, 32'hF000_0001, 32'hFFFF_FFFF, DIV_BUSY, -1, OP_NOP);

    // Squash mid-divide: HI/LO keep preloaded values.
    mt(OP_MTHI, 32'hA);
    mt(OP_MTLO, 32'hB);
    drive(OP_DIVU, 32'd100, 32'd7);
    repeat (8) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush busy low", busy_o, 1'b0);
    watch_no_done("flush", 40);
    chk("flush hi", hi_o, 32'hA);
    chk("flush lo", lo_o, 32'hB);

    // Reset mid-divide clears everything.
    drive(OP_DIVU, 32'd100, 32'd7);
    repeat (18) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst busy", busy_o, 1'b0);
    chk("rst hi", hi_o, 32'h0);
    chk("rst lo", lo_o, 32'h0);
    watch_no_done("rst", 40);

    // Start coincident with flush in IDLE is dropped.
    mt(OP_MTHI, 32'h33);
    @(negedge clk);
    start = 1'b1; op = OP_MTHI; a = 32'h55; flush = 1'b1;
    @(negedge clk);
    start = 1'b1; op = OP_DIVU; a = 32'd9; b = 32'd2;
    @(negedge clk);
    start = 1'b0; op = OP_NOP; flush = 1'b0;
    chk("idle flush hi", hi_o, 32'h33);
    watch_no_done("idle flush", 5);

    run_op("divu after", OP_DIVU, 32'd9, 32'd2, 32'd1, 32'd4, DIV_BUSY, -1, OP_NOP);
    @(negedge clk);
    cmp_en = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multi-cycle integer multiply/divide unit in the EX stage, alongside the ALU.
- Takes the same A/B operands from the ID/EX register.
- Holds the architectural HI/LO registers. Their values are forwarded to the EX result mux for MFHI/MFLO.
- Asserts busy_o so hazard control stalls IF/ID/EX while an operation is in flight.

Parameters:
N_BITS, 32, operand/HI/LO width
N_OP, 3, width of md_op_i
N_CNT, 6, iteration counter width (must hold N_BITS)

Ports:
clk_i  input  1  system clock, rising edge
reset_i  input  1  synchronous, active-high reset
start_i  input  1  request; sampled with md_op_i on a rising edge
md_op_i  input  N_OP  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (NOP)
A  input  N_BITS  rs operand (multiplicand / dividend / MTHI-MTLO source)
B  input  N_BITS  rt operand (multiplier / divisor)
flush_i  input  1  abort the in-flight operation (branch/exception squash)
busy_o  output  1  operation in flight; HI/LO not valid
done_o  output  1  one-cycle pulse when HI/LO are committed
hi_o  output  N_BITS  HI register
lo_o  output  N_BITS  LO register

Behaviour:
- Reset: synchronous, active-high. On reset, state=IDLE, busy_o=0, done_o=0, hi_o=0, lo_o=0, counter=0. Reset overrides start_i and flush_i, including mid-operation.
- States: IDLE, RUN, FIX.
- IDLE:
  - start_i=1 with MULT/MULTU/DIV/DIVU:
    - Latch |A| and |B| for signed ops, raw A and B for unsigned ops.
    - Latch the result sign flags and op.
    - Clear the accumulator, counter=0, go to RUN.
  - start_i=1 with MTHI/MTLO: write A into HI (MTHI) or LO (MTLO) at that edge. No busy, no done.
  - NOP or reserved op: no effect.
- RUN: one iteration per cycle, N_BITS cycles; counter increments and leaves RUN when counter=N_BITS-1.
  - Multiply: shift-add on a 2*N_BITS product.
  - Divide: restoring shift-subtract producing quotient and remainder.
- FIX: apply signs and commit.
  - Signed multiply: negate the 2N-bit product if sign(A)^sign(B).
  - Signed divide: quotient negated if sign(A)^sign(B); remainder takes the sign of A.
  - Writes HI = product[2N-1:N] or remainder, and LO = product[N-1:0] or quotient.
  - Pulses done_o in the following cycle; returns to IDLE.
- Latency: start accepted at edge T. busy_o=1 from T+1 through T+N_BITS+1 (33 cycles). HI/LO updated at edge T+N_BITS+1. done_o=1 and busy_o=0 in the cycle after that.
- busy_o is registered: it is 1 in RUN and FIX, 0 in IDLE.
- start_i while busy_o=1: ignored, operation unchanged. Hazard control must stall the requester.
- MTHI/MTLO while busy_o=1: ignored.
- flush_i=1 in RUN or FIX: return to IDLE next edge; HI/LO keep their previous values; no done_o.
- flush_i=1 in IDLE: a start_i in the same cycle is dropped.
- Divide by zero (B=0): no trap. LO = all ones, HI = A (raw dividend), same latency. Applies to both DIV and DIVU.
- Overflow DIV 0x80000000 / -1: LO=0x80000000, HI=0, no trap.
- MULT/MULTU: the full 64-bit result is always exact; no overflow indication.
- hi_o and lo_o are driven directly from the registers; they are not updated during RUN.

Optional Feature:
- Macro: MD_FAST_MULT_EN.
- Defined: MULT/MULTU bypass RUN and use a combinational N_BITSxN_BITS signed/unsigned product.
  - HI/LO are written at the accept edge T.
  - done_o pulses in cycle T+1; busy_o stays 0.
  - DIV/DIVU are unchanged (33 cycles).
- Undefined: all four arithmetic ops are iterative, as specified above.

Test Plan:
- Reset, then MTHI A=0x12345678 followed by MTLO A=0x9ABCDEF0 -> hi_o=0x12345678, lo_o=0x9ABCDEF0, busy_o never asserted.
- MULT A=-3 (0xFFFFFFFD), B=5 -> busy_o high for exactly 33 cycles, then done_o pulse; hi_o=0xFFFFFFFF, lo_o=0xFFFFFFF1. MULTU A=B=0xFFFFFFFF -> hi_o=0xFFFFFFFE, lo_o=0x00000001.
- DIVU A=100, B=7 -> lo_o=14, hi_o=2. DIV A=-7, B=2 -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF. DIV A=0x80000000, B=-1 -> lo_o=0x80000000, hi_o=0.
- DIV A=55, B=0 -> lo_o=0xFFFFFFFF, hi_o=55 after 33 busy cycles. Also: a second start_i mid-operation is ignored and the result matches the first op.
- Preload HI/LO=0xA/0xB, start DIVU, then flush_i at cycle 10 -> busy_o low next cycle, no done_o, hi_o=0xA, lo_o=0xB. Repeat with reset_i at cycle 20 -> hi_o=lo_o=0.
- With MD_FAST_MULT_EN: MULTU A=B=0xFFFFFFFF -> HI/LO correct at the accept edge, done_o in the next cycle, busy_o never 1. DIVU still takes 33 busy cycles.
